// File: rtl/ifetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
// Optional feature macro used by this slice: IFETCH_BRANCH_PRED_EN.
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic            valid;
    } if_id_packet_t;

    // Word select inside the fetched doubleword; PC bit 2 picks the upper half.
    function automatic logic [31:0] select_word(input logic [XLEN-1:0] pc,
                                                input logic [63:0]     line);
        return pc[2] ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/ifetch_pc_sel.sv
// Combinational next-PC priority mux: EX branch, ROB target, predictor, PC+4, hold.
// The predictor leg exists only when IFETCH_BRANCH_PRED_EN is defined.
module ifetch_pc_sel
    import ifetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_reg,
    input  logic            fetch_ok,
    input  logic            certain_branch_req,
    input  logic [XLEN-1:0] certain_branch_pc,
    input  logic            rob_target_req,
    input  logic [XLEN-1:0] rob_target_pc,
    input  logic            branch_pred_req,
    input  logic [XLEN-1:0] branch_pred_pc,
    output logic [XLEN-1:0] next_pc
);

`ifdef IFETCH_BRANCH_PRED_EN
    logic pred_taken;
    assign pred_taken = fetch_ok & branch_pred_req;
`else
    logic pred_taken;
    logic unused_pred;
    assign pred_taken  = 1'b0;
    assign unused_pred = ^{branch_pred_req, branch_pred_pc};
`endif

    // Redirects win even when the fetch itself is blocked (stall or cache miss).
    always_comb begin
        next_pc = pc_reg;
        if (certain_branch_req) begin
            next_pc = certain_branch_pc;
        end else if (rob_target_req) begin
            next_pc = rob_target_pc;
        end else if (pred_taken) begin
`ifdef IFETCH_BRANCH_PRED_EN
            next_pc = branch_pred_pc;
`else
            next_pc = pc_reg;
`endif
        end else if (fetch_ok) begin
            next_pc = pc_reg + XLEN'(4);
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: holds the fetch PC, drives the I-cache address and emits IF/ID packets.
// Build option: define IFETCH_BRANCH_PRED_EN to honour branch_pred_req/branch_pred_pc.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] certain_branch_pc,
    input  logic            certain_branch_req,
    input  logic [XLEN-1:0] rob_target_pc,
    input  logic            rob_target_req,
    input  logic            rob_stall,
    input  logic [XLEN-1:0] branch_pred_pc,
    input  logic            branch_pred_req,
    input  logic [63:0]     Icache2proc_data,
    input  logic            Icache2proc_data_valid,
    output if_id_packet_t   if_packet,
    output logic [XLEN-1:0] proc2Icache_addr
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] next_pc;
    logic            fetch_ok;

    // Handshake: if_valid is the downstream ready; an instruction transfers in a cycle
    // exactly when if_packet.valid is high, and the PC advances only on that transfer
    // (or on a redirect, which squashes the same-cycle fetch).
    assign fetch_ok = ~reset & if_valid & Icache2proc_data_valid & ~rob_stall
                    & ~certain_branch_req & ~rob_target_req;

    assign proc2Icache_addr = {pc_reg[XLEN-1:3], 3'b000};

    ifetch_pc_sel u_pc_sel (
        .pc_reg             (pc_reg),
        .fetch_ok           (fetch_ok),
        .certain_branch_req (certain_branch_req),
        .certain_branch_pc  (certain_branch_pc),
        .rob_target_req     (rob_target_req),
        .rob_target_pc      (rob_target_pc),
        .branch_pred_req    (branch_pred_req),
        .branch_pred_pc     (branch_pred_pc),
        .next_pc            (next_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= next_pc;
        end
    end

    always_comb begin
        if_packet.valid = fetch_ok;
        if_packet.inst  = fetch_ok ? select_word(pc_reg, Icache2proc_data) : NOP;
        if_packet.pc    = pc_reg;
        if_packet.npc   = reset ? RESET_PC : next_pc;
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed table-driven bench for ifetch_stage plus hand sequences for priority and mid-stream reset.
module tb_ifetch_stage;
    import ifetch_pkg::*;

    localparam logic [63:0] D0  = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] D1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [31:0] LO  = 32'hCCCC_DDDD;
    localparam logic [31:0] HI  = 32'hAAAA_BBBB;
    localparam logic [31:0] NP  = 32'h0000_0013;
`ifdef IFETCH_BRANCH_PRED_EN
    localparam logic [31:0] NPC8 = 32'h3333_3330;
`else
    localparam logic [31:0] NPC8 = 32'h2222_2230;
`endif
    localparam logic [31:0] P9 = NPC8;

    logic            clock = 1'b0;
    logic            reset;
    logic            if_valid;
    logic [31:0]     certain_branch_pc;
    logic            certain_branch_req;
    logic [31:0]     rob_target_pc;
    logic            rob_target_req;
    logic            rob_stall;
    logic [31:0]     branch_pred_pc;
    logic            branch_pred_req;
    logic [63:0]     Icache2proc_data;
    logic            Icache2proc_data_valid;
    if_id_packet_t   if_packet;
    logic [31:0]     proc2Icache_addr;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .if_valid               (if_valid),
        .certain_branch_pc      (certain_branch_pc),
        .certain_branch_req     (certain_branch_req),
        .rob_target_pc          (rob_target_pc),
        .rob_target_req         (rob_target_req),
        .rob_stall              (rob_stall),
        .branch_pred_pc         (branch_pred_pc),
        .branch_pred_req        (branch_pred_req),
        .Icache2proc_data       (Icache2proc_data),
        .Icache2proc_data_valid (Icache2proc_data_valid),
        .if_packet              (if_packet),
        .proc2Icache_addr       (proc2Icache_addr)
    );

    typedef struct {
        logic        rst, ifv, stall, dv;
        logic        cb_req;  logic [31:0] cb_pc;
        logic        rob_req; logic [31:0] rob_pc;
        logic        bp_req;  logic [31:0] bp_pc;
        logic [63:0] data;
        logic        e_valid;
        logic [31:0] e_inst, e_pc, e_npc, e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic ifv, logic stall, logic dv,
                                logic cb_req, logic [31:0] cb_pc,
                                logic rob_req, logic [31:0] rob_pc,
                                logic bp_req, logic [31:0] bp_pc, logic [63:0] data,
                                logic e_valid, logic [31:0] e_inst, logic [31:0] e_pc,
                                logic [31:0] e_npc, logic [31:0] e_addr);
        vec_t v;
        v.rst = rst; v.ifv = ifv; v.stall = stall; v.dv = dv;
        v.cb_req = cb_req; v.cb_pc = cb_pc; v.rob_req = rob_req; v.rob_pc = rob_pc;
        v.bp_req = bp_req; v.bp_pc = bp_pc; v.data = data;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc; v.e_npc = e_npc; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; if_valid = v.ifv; rob_stall = v.stall; Icache2proc_data_valid = v.dv;
        certain_branch_req = v.cb_req; certain_branch_pc = v.cb_pc;
        rob_target_req = v.rob_req; rob_target_pc = v.rob_pc;
        branch_pred_req = v.bp_req; branch_pred_pc = v.bp_pc;
        Icache2proc_data = v.data;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_pkt(input string tag, input logic e_valid, input logic [31:0] e_inst,
                             input logic [31:0] e_pc, input logic [31:0] e_npc,
                             input logic [31:0] e_addr);
        check({tag, "_valid"}, {31'd0, if_packet.valid}, {31'd0, e_valid});
        check({tag, "_inst"},  if_packet.inst, e_inst);
        check({tag, "_pc"},    if_packet.pc,   e_pc);
        check({tag, "_npc"},   if_packet.npc,  e_npc);
        check({tag, "_addr"},  proc2Icache_addr, e_addr);
    endtask

    initial begin
        //                 rst ifv stl dv  cb  cb_pc          rob rob_pc         bp  bp_pc          data  ev  inst pc            npc           addr
        tbl.push_back(mk(1, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 0, NP, 32'h0,        32'h0,        32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, LO, 32'h0,        32'h4,        32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, HI, 32'h4,        32'h8,        32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, LO, 32'h8,        32'hC,        32'h8));
        tbl.push_back(mk(0, 1, 0, 1, 1, 32'h1111_1110, 1, 32'h2222_2222, 1, 32'h3333_3333, D0, 0, NP, 32'hC,        32'h1111_1110, 32'h8));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, LO, 32'h1111_1110, 32'h1111_1114, 32'h1111_1110));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            1, 32'h2222_2228, 0, 0,            D0, 0, NP, 32'h1111_1114, 32'h2222_2228, 32'h1111_1110));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, LO, 32'h2222_2228, 32'h2222_222C, 32'h2222_2228));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            1, 32'h3333_3330, D0, 1, HI, 32'h2222_222C, NPC8,         32'h2222_2228));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, LO, P9,           P9 + 32'd4,   P9));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 0,            0, 0,            D0, 0, NP, P9 + 32'd4,   P9 + 32'd4,   P9));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 0,        0, 0,            0, 0,            D0, 0, NP, P9 + 32'd4,   P9 + 32'd4,   P9));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, HI, P9 + 32'd4,   P9 + 32'd8,   P9));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 0, NP, P9 + 32'd8,   P9 + 32'd8,   P9 + 32'd8));
        tbl.push_back(mk(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0,            0, 0,            D0, 0, NP, P9 + 32'd8,   32'hFFFF_FFFC, P9 + 32'd8));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D0, 1, HI, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFF8));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,            0, 0,            0, 0,            D1, 1, 32'h89AB_CDEF, 32'h0, 32'h4,   32'h0));

        drive(tbl[0]);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            drive(tbl[i]);
            #1;
            check_pkt($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_inst,
                      tbl[i].e_pc, tbl[i].e_npc, tbl[i].e_addr);
        end

        // ROB target outranks the predictor; PC is 4 here.
        @(negedge clock);
        rob_target_req = 1'b1; rob_target_pc = 32'h0000_0100;
        branch_pred_req = 1'b1; branch_pred_pc = 32'h0000_0200;
        Icache2proc_data = D0;
        #1;
        check_pkt("rob_vs_bp", 1'b0, NP, 32'h4, 32'h0000_0100, 32'h0);
        @(negedge clock);
        rob_target_req = 1'b0; branch_pred_req = 1'b0;
        #1;
        check_pkt("after_rob", 1'b1, LO, 32'h0000_0100, 32'h0000_0104, 32'h0000_0100);

        // Mid-stream reset at PC 0x40.
        @(negedge clock);
        certain_branch_req = 1'b1; certain_branch_pc = 32'h0000_0040;
        @(negedge clock);
        certain_branch_req = 1'b0;
        #1;
        check_pkt("at_40", 1'b1, LO, 32'h40, 32'h44, 32'h40);
        reset = 1'b1;
        #1;
        check_pkt("rst_pre_edge", 1'b0, NP, 32'h40, 32'h0, 32'h40);
        @(negedge clock);
        #1;
        check_pkt("rst_post_edge", 1'b0, NP, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_pkt("rst_release", 1'b1, LO, 32'h0, 32'h4, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
